spi_master: RTL and testbench



---
 rtl/spi_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/spi_master.sv | 149 ++++++++++++++
 tb/tb_spi_master.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Definitions shared by the SPI master and any SPI slave logic: word size, divider floor,
// bus mode and the master FSM states.
package spi_pkg;

    localparam int unsigned SPI_WORD_W   = 8;
    localparam int unsigned SPI_MIN_HALF = 4;

    // Mode 0: sck idles low, data sampled on the rising edge.
    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StXfer,
        StHold,
        StGap
    } spi_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for bringing an asynchronous input into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one byte per start, MSB first, sck derived from clk by an integer divider.
// All bus outputs are registered, so every bus edge lines up with a clk edge.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [SPI_WORD_W-1:0] din_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [SPI_WORD_W-1:0] dout_o,
    output logic                  ss_o,
    output logic                  sck_o,
    output logic                  mosi_o,
    input  logic                  miso_i
);

    localparam int unsigned W    = SPI_WORD_W;
    localparam int unsigned DivW = $clog2(HALF_PERIOD);
    localparam int unsigned BitW = $clog2(SPI_WORD_W);

    localparam logic [DivW-1:0] DivLast = DivW'(HALF_PERIOD - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(SPI_WORD_W - 1);

    if (HALF_PERIOD < SPI_MIN_HALF) begin : gen_half_too_small
        $error("spi_master: HALF_PERIOD=%0d is below the minimum of %0d",
               HALF_PERIOD, SPI_MIN_HALF);
    end

    if (CPHA != 1'b0) begin : gen_mode_unsupported
        $error("spi_master: only CPHA = 0 is implemented");
    end

    spi_state_e      state_q;
    logic [DivW-1:0] div_q;
    logic [BitW-1:0] bit_q;
    logic [W-2:0]    tx_q;
    logic [W-1:0]    rx_q;
    logic [W-1:0]    dout_q;
    logic            ss_q;
    logic            sck_q;
    logic            mosi_q;
    logic            busy_q;
    logic            done_q;

    logic            miso_sync;
    logic            div_end;

    sync_2ff u_miso_sync (
        .clk (clk),
        .rst (rst),
        .d_i (miso_i),
        .q_o (miso_sync)
    );

    assign div_end = (div_q == DivLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            ss_q    <= 1'b1;
            sck_q   <= CPOL;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // The divider free-runs across SETUP/XFER/HOLD/GAP; each phase is one wrap.
            div_q  <= div_end ? '0 : div_q + 1'b1;

            case (state_q)
                StIdle: begin
                    div_q <= '0;
                    if (start_i) begin
                        tx_q    <= din_i[W-2:0];
                        mosi_q  <= din_i[W-1];
                        bit_q   <= '0;
                        ss_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StSetup;
                    end
                end

                StSetup: begin
                    if (div_end) begin
                        sck_q   <= ~CPOL;
                        state_q <= StXfer;
                    end
                end

                StXfer: begin
                    if (div_end) begin
                        if (sck_q != CPOL) begin
                            // Closing a high phase: sample, then present the next bit.
                            sck_q <= CPOL;
                            rx_q  <= {rx_q[W-2:0], miso_sync};
                            tx_q  <= {tx_q[W-3:0], 1'b0};
                            bit_q <= bit_q + 1'b1;
                            if (bit_q == BitLast) begin
                                mosi_q  <= 1'b0;
                                state_q <= StHold;
                            end else begin
                                mosi_q <= tx_q[W-2];
                            end
                        end else begin
                            sck_q <= ~CPOL;
                        end
                    end
                end

                StHold: begin
                    if (div_end) begin
                        ss_q    <= 1'b1;
                        dout_q  <= rx_q;
                        done_q  <= 1'b1;
                        state_q <= StGap;
                    end
                end

                StGap: begin
                    if (div_end) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign dout_o = dout_q;
    assign ss_o   = ss_q;
    assign sck_o  = sck_q;
    assign mosi_o = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a HALF=4 instance under directed and random traffic and a HALF=7
// instance talking to a slave with a delayed miso, both checked against cycle-level formulas.
module tb_spi_master;

    localparam int unsigned HA = 4;
    localparam int unsigned HB = 7;

    typedef struct {
        logic [7:0]  din;
        logic [7:0]  sbyte;
        int unsigned t0;
    } xfer_t;

    typedef struct {
        logic [7:0]  dout;
        int unsigned t_done;
        int unsigned t_idle;
    } resp_t;

    logic        clk = 1'b0;
    int unsigned cyc = 0;
    int unsigned n_tests = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int unsigned act,
                                  input int unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endfunction

    // ---------------- instance A, HALF = 4 ----------------
    logic       rst_a, start_a, busy_a, done_a, ss_a, sck_a, mosi_a, miso_a;
    logic [7:0] din_a, dout_a;

    spi_master #(.HALF_PERIOD(HA)) u_dut_a (
        .clk     (clk),
        .rst     (rst_a),
        .start_i (start_a),
        .din_i   (din_a),
        .busy_o  (busy_a),
        .done_o  (done_a),
        .dout_o  (dout_a),
        .ss_o    (ss_a),
        .sck_o   (sck_a),
        .mosi_o  (mosi_a),
        .miso_i  (miso_a)
    );

    xfer_t       txq_a[$];
    resp_t       rspq_a[$];
    int unsigned idleq_a[$];
    int unsigned free_at_a = 0;
    int unsigned n_acc_a = 0;
    bit          abort_a = 1'b0;
    int unsigned viol = 0;
    bit          b_done = 1'b0;

    // Reference model: a start is taken iff the previous transfer's 18*HALF+1 cycles are over.
    task automatic step_a(input logic s, input logic [7:0] d, input logic [7:0] sb);
        start_a = s;
        din_a   = d;
        if (s && cyc >= free_at_a) begin
            txq_a.push_back('{din: d, sbyte: sb, t0: cyc});
            rspq_a.push_back('{dout: sb, t_done: cyc + 1 + 17 * HA, t_idle: cyc + 1 + 18 * HA});
            free_at_a = cyc + 1 + 18 * HA;
            n_acc_a++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_free_a();
        while (cyc < free_at_a) step_a(1'b0, 8'h00, 8'h00);
    endtask

    // Behavioural mode-0 slave A: captures mosi on sck rise, advances miso after sck fall.
    logic        ss_pa = 1'b1, sck_pa = 1'b0, mosi_pa = 1'b0, rst_pa = 1'b1;
    bit          act_a = 1'b0;
    int unsigned idx_a = 0;
    logic [7:0]  cap_a = 8'h00;
    int unsigned rises_a[$];
    xfer_t       cur_a;

    assign miso_a = (ss_a === 1'b0 && act_a && idx_a < 8) ? cur_a.sbyte[3'(7 - idx_a)] : 1'b0;

    always @(negedge clk) begin : slave_a
        if (ss_pa === 1'b1 && ss_a === 1'b0) begin
            idx_a = 0;
            cap_a = 8'h00;
            rises_a.delete();
            if (txq_a.size() == 0) begin
                act_a = 1'b0;
                check("a unexpected ss fall", 1, 0);
            end else begin
                cur_a = txq_a.pop_front();
                act_a = 1'b1;
                check("a ss fall cycle", cyc, cur_a.t0 + 1);
            end
        end
        if (sck_pa === 1'b0 && sck_a === 1'b1) begin
            rises_a.push_back(cyc);
            cap_a = {cap_a[6:0], mosi_a};
        end
        if (sck_pa === 1'b1 && sck_a === 1'b0) idx_a++;
        if (ss_pa === 1'b0 && ss_a === 1'b1 && act_a) begin
            act_a = 1'b0;
            if (abort_a) begin
                abort_a = 1'b0;
            end else begin
                check("a mosi byte", cap_a, cur_a.din);
                check("a rise count", rises_a.size(), 8);
                for (int k = 0; k < 8 && k < rises_a.size(); k++)
                    check("a rise cycle", rises_a[k], cur_a.t0 + 1 + HA * (2 * k + 1));
                check("a ss rise cycle", cyc, cur_a.t0 + 1 + 17 * HA);
            end
        end
        if (rst_pa === 1'b0) begin
            if (ss_a !== ss_pa && (sck_pa === 1'b1 || sck_a === 1'b1)) viol++;
            if (mosi_a !== mosi_pa && sck_a === 1'b1) viol++;
        end
        ss_pa   = ss_a;
        sck_pa  = sck_a;
        mosi_pa = mosi_a;
        rst_pa  = rst_a;
    end

    logic busy_pa = 1'b0;

    always @(negedge clk) begin : mon_a
        resp_t r;
        if (done_a === 1'b1) begin
            if (rspq_a.size() == 0) begin
                check("a unexpected done", 1, 0);
            end else begin
                r = rspq_a.pop_front();
                check("a dout", dout_a, r.dout);
                check("a done cycle", cyc, r.t_done);
                idleq_a.push_back(r.t_idle);
            end
        end
        if (busy_pa === 1'b1 && busy_a === 1'b0 && idleq_a.size() != 0)
            check("a busy fall cycle", cyc, idleq_a.pop_front());
        busy_pa = busy_a;
    end

    // ---------------- instance B, HALF = 7, slave with 3-clk miso delay ----------------
    logic       rst_b, start_b, busy_b, done_b, ss_b, sck_b, mosi_b;
    logic       miso_b = 1'b0;
    logic [7:0] din_b, dout_b;

    spi_master #(.HALF_PERIOD(HB)) u_dut_b (
        .clk     (clk),
        .rst     (rst_b),
        .start_i (start_b),
        .din_i   (din_b),
        .busy_o  (busy_b),
        .done_o  (done_b),
        .dout_o  (dout_b),
        .ss_o    (ss_b),
        .sck_o   (sck_b),
        .mosi_o  (mosi_b),
        .miso_i  (miso_b)
    );

    localparam logic [7:0] SByteB = 8'h5A;
    localparam logic [7:0] DinB   = 8'hC3;

    resp_t       rspq_b[$];
    int unsigned t0b = 0;
    logic        ss_pb = 1'b1, sck_pb = 1'b0, busy_pb = 1'b0;
    int unsigned idx_b = 0, dly_b = 0;
    logic [7:0]  cap_b = 8'h00;
    logic [7:0]  sb_b;
    int unsigned rises_b[$], falls_b[$];

    always @(negedge clk) begin : slave_b
        resp_t r;
        sb_b = SByteB;
        if (ss_pb === 1'b1 && ss_b === 1'b0) begin
            check("b ss fall cycle", cyc, t0b + 1);
            idx_b = 0;
            dly_b = 3;
            cap_b = 8'h00;
        end else if (sck_pb === 1'b1 && sck_b === 1'b0) begin
            falls_b.push_back(cyc);
            idx_b++;
            dly_b = 3;
        end else if (dly_b > 0) begin
            dly_b--;
            if (dly_b == 0) miso_b = (idx_b < 8) ? sb_b[3'(7 - idx_b)] : 1'b0;
        end
        if (sck_pb === 1'b0 && sck_b === 1'b1) begin
            rises_b.push_back(cyc);
            cap_b = {cap_b[6:0], mosi_b};
        end
        if (ss_pb === 1'b0 && ss_b === 1'b1) begin
            check("b mosi byte", cap_b, DinB);
            check("b ss rise cycle", cyc, t0b + 1 + 17 * HB);
            check("b edge counts", rises_b.size() + falls_b.size(), 16);
            for (int k = 0; k < 8 && k < rises_b.size() && k < falls_b.size(); k++) begin
                check("b rise cycle", rises_b[k], t0b + 1 + HB * (2 * k + 1));
                check("b fall cycle", falls_b[k], t0b + 1 + HB * (2 * k + 2));
            end
        end
        if (done_b === 1'b1) begin
            if (rspq_b.size() == 0) begin
                check("b unexpected done", 1, 0);
            end else begin
                r = rspq_b.pop_front();
                check("b dout", dout_b, r.dout);
                check("b done cycle", cyc, r.t_done);
                check("b ss high at done", ss_b, 1);
            end
        end
        if (busy_pb === 1'b1 && busy_b === 1'b0)
            check("b busy fall cycle", cyc, t0b + 1 + 18 * HB);
        ss_pb   = ss_b;
        sck_pb  = sck_b;
        busy_pb = busy_b;
    end

    initial begin : run_b
        rst_b   = 1'b1;
        start_b = 1'b0;
        din_b   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_b = 1'b0;
        check("b reset ss", ss_b, 1);
        check("b reset sck", sck_b, 0);
        repeat (2) @(posedge clk);
        #1;
        t0b     = cyc;
        start_b = 1'b1;
        din_b   = DinB;
        rspq_b.push_back('{dout: SByteB, t_done: t0b + 1 + 17 * HB, t_idle: t0b + 1 + 18 * HB});
        @(posedge clk);
        #1;
        start_b = 1'b0;
        while (cyc < t0b + 18 * HB + 4) @(posedge clk);
        #1;
        check("b responses outstanding", rspq_b.size(), 0);
        b_done = 1'b1;
    end

    // ---------------- main sequence on instance A ----------------
    initial begin : run_a
        int unsigned t0;
        int unsigned n0;
        rst_a   = 1'b1;
        start_a = 1'b0;
        din_a   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        check("a reset ss", ss_a, 1);
        check("a reset sck", sck_a, 0);
        check("a reset mosi", mosi_a, 0);
        check("a reset busy", busy_a, 0);
        check("a reset done", done_a, 0);
        check("a reset dout", dout_a, 0);
        free_at_a = cyc;

        // 0x3C out, slave answers 0xA5
        step_a(1'b1, 8'h3C, 8'hA5);
        wait_free_a();

        // start held high across two transfers
        n0 = n_acc_a;
        step_a(1'b1, 8'h00, 8'h81);
        while (n_acc_a < n0 + 2) step_a(1'b1, 8'hFF, 8'h7E);
        wait_free_a();

        // start during busy is dropped; start on first idle cycle is taken
        step_a(1'b1, 8'h11, 8'h22);
        repeat (20) step_a(1'b0, 8'h00, 8'h00);
        step_a(1'b1, 8'h99, 8'h66);
        wait_free_a();
        check("a busy low at first idle cycle", busy_a, 0);
        step_a(1'b1, 8'h42, 8'h24);
        wait_free_a();

        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) step_a(1'b0, 8'($urandom), 8'h00);
            step_a(1'b1, 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 40)) step_a(1'b0, 8'($urandom), 8'h00);
                step_a(1'b1, 8'($urandom), 8'($urandom));
            end
            wait_free_a();
        end

        // reset at the 4th rising edge aborts the byte
        t0 = cyc;
        step_a(1'b1, 8'hE7, 8'h3B);
        while (cyc < t0 + 1 + 7 * HA) step_a(1'b0, 8'h00, 8'h00);
        check("a sck high at 4th rise", sck_a, 1);
        rst_a   = 1'b1;
        abort_a = 1'b1;
        void'(rspq_a.pop_back());
        step_a(1'b0, 8'h00, 8'h00);
        rst_a     = 1'b0;
        free_at_a = cyc;
        check("a abort ss", ss_a, 1);
        check("a abort sck", sck_a, 0);
        check("a abort busy", busy_a, 0);
        check("a abort done", done_a, 0);
        check("a abort dout", dout_a, 0);
        check("a abort mosi", mosi_a, 0);
        repeat (80) step_a(1'b0, 8'h00, 8'h00);

        step_a(1'b1, 8'h5C, 8'hC5);
        wait_free_a();
        repeat (4) step_a(1'b0, 8'h00, 8'h00);

        while (!b_done) @(posedge clk);
        check("a responses outstanding", rspq_a.size(), 0);
        check("a transfers outstanding", txq_a.size(), 0);
        check("a protocol violations", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
